etc_pixel_decoder: RTL and testbench

- Downstream consumer of the ETC block fetcher.
- Per pixel request, decodes one texel from the current 64-bit ETC1/ETC2-individual/differential block into 24-bit RGB.
- Computes the framebuffer address and writes the texel through a ready/enable write port.
- Returns a one-cycle write_finish pulse that advances the fetcher's pixel index.

---
 rtl/etc_pixel_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_etc_pixel_decoder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/etc_pixel_decoder.sv
// ETC1 / ETC2 individual+differential texel decoder with framebuffer write port.
// Decodes one texel per request, writes it through a ready/enable port and
// pulses write_finish so the block fetcher can advance to the next pixel.
//
// state | meaning
// IDLE  | waiting for a valid request with pixIdx < 16
// DEC1  | base colours, table select, subblock and modifier lookup
// DEC2  | base + modifier with clamp, address computation
// WRITE | wr_en high, hold until wr_ready
// DONE  | one-cycle write_finish, pixel counter advance
// HOLD  | absorb the fetcher's late valid drop
module etc_pixel_decoder #(
  parameter int          IMG_W     = 128,
  parameter int          ADDR_W    = 14,
  parameter int          PIX_TOTAL = 16384,
  parameter logic [23:0] ERR_COLOR = 24'hFF00FF
) (
  input  logic              sclk,
  input  logic              rsrt_n,
  input  logic              valid,
  input  logic [63:0]       block_in,
  input  logic [7:0]        blockX_in,
  input  logic [7:0]        blockY_in,
  input  logic [4:0]        pixIdx_in,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              write_finish,
  output logic              err_mode,
  output logic              frame_done
);

  localparam int CNT_W = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DEC1, S_DEC2, S_WRITE, S_DONE, S_HOLD
  } state_t;

  state_t state, state_d;

  logic [63:0]      blk_q;
  logic [7:0]       bx_q, by_q;
  logic [3:0]       pix_q;
  logic [23:0]      col_q;
  logic [8:0]       mod_q;
  logic             err_q;
  logic [CNT_W-1:0] pix_cnt;

  logic       accept;
  logic [1:0] px, py;
  logic [5:0] k_lo, k_hi;
  logic [1:0] tidx;
  logic       sub2;
  logic [2:0] tbl;
  logic [7:0] mag;
  logic [8:0] mod_d;
  logic [6:0] sr, sg, sb;
  logic       err_d;
  logic [23:0] col1, col2, col_d;
  logic [23:0] pix_rgb;
  logic [31:0] row_full, col_full, addr_full;

  function automatic logic [6:0] add_delta(input logic [4:0] base, input logic [2:0] d);
    return {2'b00, base} + {{4{d[2]}}, d};
  endfunction

  function automatic logic [7:0] exp5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] tbl_val(input logic [2:0] t, input logic sel_b);
    logic [7:0] a, b;
    case (t)
      3'd0:    begin a = 8'd2;  b = 8'd8;   end
      3'd1:    begin a = 8'd5;  b = 8'd17;  end
      3'd2:    begin a = 8'd9;  b = 8'd29;  end
      3'd3:    begin a = 8'd13; b = 8'd42;  end
      3'd4:    begin a = 8'd18; b = 8'd60;  end
      3'd5:    begin a = 8'd24; b = 8'd80;  end
      3'd6:    begin a = 8'd33; b = 8'd106; end
      default: begin a = 8'd47; b = 8'd183; end
    endcase
    return sel_b ? b : a;
  endfunction

  // Signed 10-bit add of an 8-bit channel and a 9-bit signed modifier, clamped to 0..255.
  function automatic logic [7:0] clamp_add(input logic [7:0] c, input logic [8:0] m);
    logic [9:0] s;
    s = {2'b00, c} + {m[8], m};
    if (s[9])      return 8'h00;
    else if (s[8]) return 8'hFF;
    else           return s[7:0];
  endfunction

  assign accept = (state == S_IDLE) && valid && !pixIdx_in[4];

  // Colour selection and modifier lookup from the captured block.
  always_comb begin
    px    = pix_q[1:0];
    py    = pix_q[3:2];
    k_lo  = {2'b00, px, py};
    k_hi  = {2'b01, px, py};
    tidx  = {blk_q[k_hi], blk_q[k_lo]};
    sub2  = blk_q[32] ? py[1] : px[1];
    tbl   = sub2 ? blk_q[36:34] : blk_q[39:37];
    mag   = tbl_val(tbl, tidx[0]);
    mod_d = tidx[1] ? (9'd0 - {1'b0, mag}) : {1'b0, mag};
    sr    = add_delta(blk_q[63:59], blk_q[58:56]);
    sg    = add_delta(blk_q[55:51], blk_q[50:48]);
    sb    = add_delta(blk_q[47:43], blk_q[42:40]);
    err_d = 1'b0;
    if (blk_q[33]) begin
      col1  = {exp5(blk_q[63:59]), exp5(blk_q[55:51]), exp5(blk_q[47:43])};
      col2  = {exp5(sr[4:0]), exp5(sg[4:0]), exp5(sb[4:0])};
      // any channel leaving 0..31 marks a T, H or planar block
      err_d = (sr[6:5] != 2'b00) || (sg[6:5] != 2'b00) || (sb[6:5] != 2'b00);
    end else begin
      col1 = {blk_q[63:60], blk_q[63:60], blk_q[55:52], blk_q[55:52],
              blk_q[47:44], blk_q[47:44]};
      col2 = {blk_q[59:56], blk_q[59:56], blk_q[51:48], blk_q[51:48],
              blk_q[43:40], blk_q[43:40]};
    end
    col_d = sub2 ? col2 : col1;
  end

  // Final texel colour and framebuffer address from the DEC1 registers.
  always_comb begin
    pix_rgb   = {clamp_add(col_q[23:16], mod_q), clamp_add(col_q[15:8], mod_q),
                 clamp_add(col_q[7:0], mod_q)};
    row_full  = {22'd0, by_q, 2'b00} + {30'd0, pix_q[3:2]};
    col_full  = {22'd0, bx_q, 2'b00} + {30'd0, pix_q[1:0]};
    addr_full = row_full * 32'(IMG_W) + col_full;
  end

  // State register.
  always_ff @(posedge sclk or negedge rsrt_n) begin
    if (!rsrt_n) state <= S_IDLE;
    else         state <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d      = state;
    wr_en        = 1'b0;
    write_finish = 1'b0;
    case (state)
      S_IDLE:  if (accept) state_d = S_DEC1;
      S_DEC1:  state_d = S_DEC2;
      S_DEC2:  state_d = S_WRITE;
      S_WRITE: begin
        wr_en = 1'b1;
        if (wr_ready) state_d = S_DONE;
      end
      S_DONE: begin
        write_finish = 1'b1;
        state_d      = S_HOLD;
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture on the accepting IDLE edge.
  always_ff @(posedge sclk or negedge rsrt_n) begin
    if (!rsrt_n) begin
      blk_q <= '0;
      bx_q  <= '0;
      by_q  <= '0;
      pix_q <= '0;
    end else if (accept) begin
      blk_q <= block_in;
      bx_q  <= blockX_in;
      by_q  <= blockY_in;
      pix_q <= pixIdx_in[3:0];
    end
  end

  // DEC1 pipeline registers.
  always_ff @(posedge sclk or negedge rsrt_n) begin
    if (!rsrt_n) begin
      col_q <= '0;
      mod_q <= '0;
      err_q <= 1'b0;
    end else if (state == S_DEC1) begin
      col_q <= col_d;
      mod_q <= mod_d;
      err_q <= err_d;
    end
  end

  // DEC2 output registers; they stay put through WRITE.
  always_ff @(posedge sclk or negedge rsrt_n) begin
    if (!rsrt_n) begin
      wr_data  <= '0;
      wr_addr  <= '0;
      err_mode <= 1'b0;
    end else if (state == S_DEC2) begin
      wr_data <= err_q ? ERR_COLOR : pix_rgb;
      wr_addr <= addr_full[ADDR_W-1:0];
      if (err_q) err_mode <= 1'b1;
    end
  end

  // Pixel counter and sticky frame completion flag.
  always_ff @(posedge sclk or negedge rsrt_n) begin
    if (!rsrt_n) begin
      pix_cnt    <= '0;
      frame_done <= 1'b0;
    end else if (state == S_DONE) begin
      if (pix_cnt == CNT_W'(PIX_TOTAL - 1)) begin
        pix_cnt    <= '0;
        frame_done <= 1'b1;
      end else begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_etc_pixel_decoder.sv
// Directed testbench for etc_pixel_decoder. Frame size is shrunk so the
// frame_done boundary is reachable in a short run.
module tb_etc_pixel_decoder;

  localparam int PT = 20;

  logic        sclk = 1'b0;
  logic        rsrt_n;
  logic        valid;
  logic [63:0] block_in;
  logic [7:0]  blockX_in, blockY_in;
  logic [4:0]  pixIdx_in;
  logic        wr_ready;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [23:0] wr_data;
  logic        write_finish, err_mode, frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int fin_cnt = 0;

  etc_pixel_decoder #(.IMG_W(128), .ADDR_W(14), .PIX_TOTAL(PT), .ERR_COLOR(24'hFF00FF)) dut (
    .sclk(sclk), .rsrt_n(rsrt_n), .valid(valid), .block_in(block_in),
    .blockX_in(blockX_in), .blockY_in(blockY_in), .pixIdx_in(pixIdx_in),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .write_finish(write_finish), .err_mode(err_mode), .frame_done(frame_done)
  );

  always #5 sclk = ~sclk;

  always @(negedge sclk) if (write_finish === 1'b1) fin_cnt++;

  // Drives one request; valid stays high through HOLD and drops in IDLE.
  // lat counts clock edges from valid launch to wr_en seen high.
  task automatic run_pixel(input logic [63:0] blk, input logic [7:0] bx, input logic [7:0] by,
                           input logic [4:0] idx, input int stall, output int lat,
                           output logic [23:0] data, output logic [13:0] addr, output logic hs_ok);
    hs_ok = 1'b1;
    lat   = 0;
    @(negedge sclk);
    valid = 1'b1; block_in = blk; blockX_in = bx; blockY_in = by; pixIdx_in = idx;
    wr_ready = (stall == 0);
    do begin
      @(negedge sclk);
      lat++;
      if (write_finish !== 1'b0) hs_ok = 1'b0;
    end while (wr_en !== 1'b1 && lat < 20);
    data = wr_data;
    addr = wr_addr;
    if (wr_en !== 1'b1) begin
      hs_ok = 1'b0;
      valid = 1'b0;
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge sclk);
      if (wr_en !== 1'b1 || wr_data !== data || wr_addr !== addr || write_finish !== 1'b0)
        hs_ok = 1'b0;
    end
    wr_ready = 1'b1;
    @(negedge sclk);
    if (write_finish !== 1'b1 || wr_en !== 1'b0) hs_ok = 1'b0;
    @(negedge sclk);
    if (write_finish !== 1'b0 || wr_en !== 1'b0) hs_ok = 1'b0;
    @(negedge sclk);
    if (write_finish !== 1'b0 || wr_en !== 1'b0) hs_ok = 1'b0;
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rsrt_n = 1'b0; valid = 1'b0; block_in = '0; blockX_in = '0; blockY_in = '0;
    pixIdx_in = '0; wr_ready = 1'b0;
    repeat (3) @(negedge sclk);
    n_cmp++;
    if ({wr_en, write_finish, err_mode, frame_done, wr_addr, wr_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got en=%b fin=%b err=%b fd=%b addr=%0d data=%h want all zero",
               wr_en, write_finish, err_mode, frame_done, wr_addr, wr_data);
    end
    rsrt_n = 1'b1;
  endtask

  task automatic test_individual();
    int lat; logic [23:0] d; logic [13:0] a; logic ok; int f0;
    f0 = fin_cnt;
    for (int i = 0; i < 16; i++) begin
      run_pixel(64'h8888_8800_0000_0000, 8'd0, 8'd0, 5'(i), 0, lat, d, a, ok);
      n_cmp++;
      if (d !== 24'h8A8A8A) begin
        n_bad++; $display("FAIL indiv_data[%0d]: got %h want 8a8a8a", i, d);
      end
      n_cmp++;
      if (lat !== 3 || ok !== 1'b1) begin
        n_bad++; $display("FAIL indiv_handshake[%0d]: got lat=%0d ok=%b want lat=3 ok=1", i, lat, ok);
      end
    end
    n_cmp++;
    if (fin_cnt - f0 !== 16) begin
      n_bad++; $display("FAIL indiv_finish_count: got %0d want 16", fin_cnt - f0);
    end
    n_cmp++;
    if (err_mode !== 1'b0) begin
      n_bad++; $display("FAIL indiv_err_mode: got %b want 0", err_mode);
    end
  endtask

  task automatic test_clamp();
    int lat; logic [23:0] d; logic [13:0] a; logic ok;
    run_pixel(64'hFFFF_FF00_0000_0000, 8'd0, 8'd0, 5'd0, 0, lat, d, a, ok);
    n_cmp++;
    if (d !== 24'hFFFFFF) begin
      n_bad++; $display("FAIL clamp_high: got %h want ffffff", d);
    end
    run_pixel(64'h0000_00E0_FFFF_FFFF, 8'd0, 8'd0, 5'd0, 0, lat, d, a, ok);
    n_cmp++;
    if (d !== 24'h000000) begin
      n_bad++; $display("FAIL clamp_low: got %h want 000000", d);
    end
  endtask

  task automatic test_differential();
    logic [4:0]  idx [4] = '{5'd0, 5'd5, 5'd2, 5'd15};
    logic [23:0] exp [4] = '{24'h484848, 24'h484848, 24'hF7F7F7, 24'hF7F7F7};
    int lat; logic [23:0] d; logic [13:0] a; logic ok;
    for (int i = 0; i < 4; i++) begin
      run_pixel(64'hF8F8_F8E2_FFFF_FFFF, 8'd0, 8'd0, idx[i], 0, lat, d, a, ok);
      n_cmp++;
      if (d !== exp[i] || ok !== 1'b1) begin
        n_bad++; $display("FAIL diff_data[pix %0d]: got %h ok=%b want %h ok=1", idx[i], d, ok, exp[i]);
      end
    end
    n_cmp++;
    if (err_mode !== 1'b0) begin
      n_bad++; $display("FAIL diff_err_mode: got %b want 0", err_mode);
    end
  endtask

  task automatic test_unsupported();
    int lat; logic [23:0] d; logic [13:0] a; logic ok;
    run_pixel(64'hF9F8_F8E2_FFFF_FFFF, 8'd0, 8'd0, 5'd0, 0, lat, d, a, ok);
    n_cmp++;
    if (d !== 24'hFF00FF) begin
      n_bad++; $display("FAIL unsup_data: got %h want ff00ff", d);
    end
    n_cmp++;
    if (err_mode !== 1'b1) begin
      n_bad++; $display("FAIL unsup_err_set: got %b want 1", err_mode);
    end
    run_pixel(64'h8888_8800_0000_0000, 8'd0, 8'd0, 5'd3, 0, lat, d, a, ok);
    n_cmp++;
    if (d !== 24'h8A8A8A || err_mode !== 1'b1) begin
      n_bad++; $display("FAIL unsup_sticky: got data=%h err=%b want 8a8a8a err=1", d, err_mode);
    end
  endtask

  task automatic test_address();
    logic [7:0]  bx  [3] = '{8'd5, 8'd31, 8'd0};
    logic [7:0]  by  [3] = '{8'd2, 8'd31, 8'd32};
    logic [4:0]  pi  [3] = '{5'd6, 5'd15, 5'd0};
    logic [13:0] exp [3] = '{14'd1174, 14'd16383, 14'd0};
    int lat; logic [23:0] d; logic [13:0] a; logic ok;
    for (int i = 0; i < 3; i++) begin
      run_pixel(64'h8888_8800_0000_0000, bx[i], by[i], pi[i], 0, lat, d, a, ok);
      n_cmp++;
      if (a !== exp[i]) begin
        n_bad++; $display("FAIL address[%0d]: got %0d want %0d", i, a, exp[i]);
      end
    end
  endtask

  task automatic test_ignore_idx();
    logic seen;
    seen = 1'b0;
    @(negedge sclk);
    valid = 1'b1; pixIdx_in = 5'd16; wr_ready = 1'b1;
    repeat (8) begin
      @(negedge sclk);
      if (wr_en !== 1'b0) seen = 1'b1;
    end
    valid = 1'b0;
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL ignore_idx16: got wr_en=1 seen want none");
    end
  endtask

  task automatic test_back_pressure();
    int lat; logic [23:0] d; logic [13:0] a; logic ok; int f0; logic extra;
    f0 = fin_cnt;
    extra = 1'b0;
    run_pixel(64'hF8F8_F8E2_FFFF_FFFF, 8'd5, 8'd2, 5'd6, 5, lat, d, a, ok);
    repeat (8) begin
      @(negedge sclk);
      if (wr_en !== 1'b0) extra = 1'b1;
    end
    n_cmp++;
    if (ok !== 1'b1 || d !== 24'hF7F7F7 || a !== 14'd1174) begin
      n_bad++; $display("FAIL backpressure_stall: got ok=%b data=%h addr=%0d want ok=1 data=f7f7f7 addr=1174", ok, d, a);
    end
    n_cmp++;
    if (fin_cnt - f0 !== 1 || extra !== 1'b0) begin
      n_bad++; $display("FAIL backpressure_single: got finishes=%0d extra=%b want 1 extra=0", fin_cnt - f0, extra);
    end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic [23:0] d; logic [13:0] a; logic ok; int f0; int n;
    @(negedge sclk);
    valid = 1'b1; block_in = 64'h8888_8800_0000_0000; blockX_in = '0; blockY_in = '0;
    pixIdx_in = 5'd0; wr_ready = 1'b0;
    n = 0;
    do begin @(negedge sclk); n++; end while (wr_en !== 1'b1 && n < 20);
    n_cmp++;
    if (wr_en !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_reach_write: got wr_en=%b want 1", wr_en);
    end
    f0 = fin_cnt;
    rsrt_n = 1'b0;
    #1;
    n_cmp++;
    if (wr_en !== 1'b0 || write_finish !== 1'b0 || err_mode !== 1'b0 || frame_done !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_outputs: got en=%b fin=%b err=%b fd=%b want 0000",
                        wr_en, write_finish, err_mode, frame_done);
    end
    valid = 1'b0;
    repeat (2) @(negedge sclk);
    rsrt_n = 1'b1;
    repeat (2) @(negedge sclk);
    n_cmp++;
    if (fin_cnt !== f0) begin
      n_bad++; $display("FAIL rst_mid_no_finish: got %0d extra finishes want 0", fin_cnt - f0);
    end
    run_pixel(64'h8888_8800_0000_0000, 8'd0, 8'd0, 5'd1, 0, lat, d, a, ok);
    n_cmp++;
    if (lat !== 3 || ok !== 1'b1 || d !== 24'h8A8A8A) begin
      n_bad++; $display("FAIL rst_mid_recover: got lat=%0d ok=%b data=%h want 3 1 8a8a8a", lat, ok, d);
    end
  endtask

  // One pixel already counted since the mid-write reset.
  task automatic test_frame_done();
    int lat; logic [23:0] d; logic [13:0] a; logic ok;
    for (int i = 0; i < PT - 2; i++)
      run_pixel(64'h8888_8800_0000_0000, 8'd0, 8'd0, 5'd0, 0, lat, d, a, ok);
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_bad++; $display("FAIL frame_done_early: got %b want 0 after %0d writes", frame_done, PT - 1);
    end
    run_pixel(64'h8888_8800_0000_0000, 8'd0, 8'd0, 5'd0, 0, lat, d, a, ok);
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_bad++; $display("FAIL frame_done_set: got %b want 1 after %0d writes", frame_done, PT);
    end
    run_pixel(64'h8888_8800_0000_0000, 8'd0, 8'd0, 5'd0, 0, lat, d, a, ok);
    n_cmp++;
    if (frame_done !== 1'b1 || ok !== 1'b1) begin
      n_bad++; $display("FAIL frame_done_sticky: got fd=%b ok=%b want 1 1", frame_done, ok);
    end
  endtask

  initial begin
    test_reset();
    test_individual();
    test_clamp();
    test_differential();
    test_unsupported();
    test_address();
    test_ignore_idx();
    test_back_pressure();
    test_reset_mid_write();
    test_frame_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
